// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encodings and default word width,
// common to the slave and master sides.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // Bit counter must be able to represent a full word count.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the transmit/receive word handshake of the SPI slave.
interface spi_slave_if #(
  parameter int data_width = spi_pkg::DEFAULT_DATA_WIDTH
) ();

  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [data_width-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [data_width-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  tx_underrun;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, LSB first, oversampled by clk, with a one-entry
// transmit buffer and a single-cycle receive strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam int CW = cnt_width(data_width);

  logic                  w_sclk_s;
  logic                  w_cs_s;
  logic                  w_mosi_s;
  logic                  r_sclk_d;
  logic                  r_cs_d;
  logic [1:0]            r_flush;
  logic                  r_armed;

  spi_state_t            r_state;
  spi_state_t            w_state_nxt;

  logic [CW-1:0]         r_bit_cnt;
  logic [data_width-1:0] r_tx_shift;
  logic [data_width-1:0] r_rx_shift;
  logic [data_width-1:0] r_rx_data;
  logic [data_width-1:0] r_tx_buf;
  logic                  r_buf_full;
  logic                  r_rx_valid;
  logic                  r_underrun;

  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic                  w_act;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_bit;
  logic                  w_word_done;
  logic                  w_wr;
  logic [data_width-1:0] w_rx_word;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.sclk),
    .o_sync  (w_sclk_s)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.cs),
    .o_sync  (w_cs_s)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.mosi),
    .o_sync  (w_mosi_s)
  );

  // A cs fall only counts once cs has been seen high after the synchronizers
  // have flushed their reset value, so a cs held low across reset is ignored.
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  assign w_act       = (r_state == ACTIVE) && !w_cs_rise;
  assign w_start     = (r_state == IDLE) && w_cs_fall;
  assign w_abort     = (r_state == ACTIVE) && w_cs_rise;
  assign w_load      = w_start || (w_act && w_sclk_fall && (r_bit_cnt == '0));
  assign w_shift     = w_act && w_sclk_fall && (r_bit_cnt != '0);
  assign w_bit       = w_act && w_sclk_rise;
  assign w_word_done = w_bit && (r_bit_cnt == CW'(data_width - 1));
  assign w_rx_word   = {w_mosi_s, r_rx_shift[data_width-1:1]};
  assign w_wr        = bus.tx_valid && !r_buf_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.miso = 1'b0;
    if (r_state == ACTIVE) begin
      bus.busy = 1'b1;
      bus.miso = r_tx_shift[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_d   <= 1'b0;
      r_cs_d     <= 1'b1;
      r_flush    <= 2'd0;
      r_armed    <= 1'b0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_tx_buf   <= '0;
      r_buf_full <= 1'b0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk_s;
      r_cs_d     <= w_cs_s;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (r_flush != 2'd2) r_flush <= r_flush + 2'd1;
      if (r_flush == 2'd2 && w_cs_s) r_armed <= 1'b1;

      // An empty buffer at load time sends zeros; a same-cycle write is
      // stored for the next load rather than bypassed.
      if (w_load) begin
        r_tx_shift <= r_buf_full ? r_tx_buf : '0;
        r_underrun <= ~r_buf_full;
      end else if (w_shift) begin
        r_tx_shift <= {1'b0, r_tx_shift[data_width-1:1]};
      end

      if (w_wr) begin
        r_tx_buf   <= bus.tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if (w_start || w_abort) begin
        r_bit_cnt <= '0;
      end else if (w_bit) begin
        r_rx_shift <= w_rx_word;
        if (w_word_done) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.tx_ready    = ~r_buf_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave, checked against a word-level
// model of the transmit buffer and the received words.
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;

  spi_slave_if #(.data_width(8)) bus ();

  spi_slave #(.data_width(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;

  // Word-level reference model
  bit         m_full = 1'b0;
  logic [7:0] m_buf  = 8'h00;
  logic [7:0] m_cur  = 8'h00;
  int         m_ur   = 0;
  int         m_rx   = 0;

  always @(posedge clk) begin
    if (bus.rx_valid)    rx_cnt <= rx_cnt + 1;
    if (bus.tx_underrun) ur_cnt <= ur_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_load();
    if (m_full) begin
      m_cur  = m_buf;
      m_full = 1'b0;
    end else begin
      m_cur = 8'h00;
      m_ur++;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    chk("tx_ready", {31'd0, bus.tx_ready}, {31'd0, !m_full});
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endtask

  task automatic spi_bits(input logic [7:0] m, input int n, output logic [7:0] c);
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      bus.mosi = m[i];
      tick(6);
      c[i] = bus.miso;
      bus.sclk = 1'b1;
      tick(6);
      bus.sclk = 1'b0;
    end
    tick(6);
  endtask

  task automatic begin_xfer(input string tag);
    bus.cs = 1'b0;
    m_load();
    tick(6);
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, " underrun@cs"}, ur_cnt, m_ur);
  endtask

  task automatic end_xfer(input string tag);
    bus.cs = 1'b1;
    tick(6);
    chk({tag, " idle busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_word(input string tag, input logic [7:0] m);
    logic [7:0] c;
    logic [7:0] exp_tx;
    exp_tx = m_cur;
    spi_bits(m, 8, c);
    m_rx++;
    m_load();
    chk({tag, " miso"}, {24'd0, c}, {24'd0, exp_tx});
    chk({tag, " rx_data"}, {24'd0, bus.rx_data}, {24'd0, m});
    chk({tag, " rx_cnt"}, rx_cnt, m_rx);
    chk({tag, " underrun"}, ur_cnt, m_ur);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " miso"},        {31'd0, bus.miso},        32'd0);
    chk({tag, " rx_valid"},    {31'd0, bus.rx_valid},    32'd0);
    chk({tag, " tx_ready"},    {31'd0, bus.tx_ready},    32'd1);
    chk({tag, " busy"},        {31'd0, bus.busy},        32'd0);
    chk({tag, " tx_underrun"}, {31'd0, bus.tx_underrun}, 32'd0);
    chk({tag, " rx_data"},     {24'd0, bus.rx_data},     32'd0);
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] r;
    int rx_before;
    int ur_before;

    reset        = 1'b1;
    bus.sclk     = 1'b0;
    bus.cs       = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);
    chk_reset_outputs("reset");

    // Single word
    tx_write(8'hA5);
    begin_xfer("single");
    do_word("single", 8'h3C);
    end_xfer("single");

    // Back-to-back words with cs held low
    tx_write(8'h11);
    chk("b2b tx_ready full", {31'd0, bus.tx_ready}, 32'd0);
    begin_xfer("b2b");
    tx_write(8'h22);
    do_word("b2b w0", 8'($urandom));
    do_word("b2b w1", 8'($urandom));
    end_xfer("b2b");

    // Underrun
    begin_xfer("underrun");
    do_word("underrun", 8'($urandom));
    end_xfer("underrun");

    // Abort after 5 bits, buffer written mid-transfer must survive
    tx_write(8'($urandom));
    begin_xfer("abort");
    r = 8'($urandom);
    tx_write(r);
    rx_before = rx_cnt;
    spi_bits(8'($urandom), 5, c);
    chk("abort partial miso", {27'd0, c[4:0]}, {27'd0, m_cur[4:0]});
    end_xfer("abort");
    chk("abort rx_cnt", rx_cnt, rx_before);
    begin_xfer("post-abort");
    do_word("post-abort", 8'($urandom));
    end_xfer("post-abort");

    // Reset after 3 bits with cs still low
    tx_write(8'($urandom));
    begin_xfer("rst");
    spi_bits(8'($urandom), 3, c);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_full = 1'b0;
    tick(4);
    chk_reset_outputs("mid-reset");
    rx_before = rx_cnt;
    ur_before = ur_cnt;
    spi_bits(8'hFF, 8, c);
    chk("rst no xfer busy", {31'd0, bus.busy}, 32'd0);
    chk("rst no xfer miso", {24'd0, c}, 32'd0);
    chk("rst no xfer rx_cnt", rx_cnt, rx_before);
    chk("rst no xfer underrun", ur_cnt, ur_before);
    bus.cs = 1'b1;
    tick(6);
    tx_write(8'($urandom));
    begin_xfer("post-rst");
    do_word("post-rst", 8'($urandom));
    end_xfer("post-rst");

    // Write while full keeps the first value
    tx_write(8'h5A);
    chk("full tx_ready", {31'd0, bus.tx_ready}, 32'd0);
    tx_write(8'hC3);
    begin_xfer("full");
    do_word("full", 8'($urandom));
    end_xfer("full");

    // Randomized transfers
    for (int it = 0; it < 8; it++) begin
      int nw;
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      begin_xfer("rand");
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 1) == 1 && !m_full) tx_write(8'($urandom));
        do_word("rand", 8'($urandom));
      end
      end_xfer("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
